// File: rtl/deser_pkg.sv
// Shared types and default sizing for the deserializer queue.
package deser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PUSH  = 2'd2
   } deser_state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;

endpackage : deser_pkg

// File: rtl/word_fifo.sv
// Show-ahead circular word buffer with push/pop/flush and an occupancy count.
// A push while full is taken only if a pop frees the slot in the same cycle.
module word_fifo
   import deser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] len,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (len == CNT_W'(DEPTH));
   assign empty   = (len == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head word is presented combinationally; forced to zero when nothing is stored.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage write.
   // NOTE: the array has no reset -- stale contents are never visible because
   // rd_data is gated by empty, and resetting RAM would prevent memory inference.
   always_ff @(posedge clock) begin
      if (!flush && do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         len    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         len    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   len <= len + CNT_W'(1);
            2'b01:   len <= len - CNT_W'(1);
            default: len <= len;
         endcase
      end
   end

endmodule : word_fifo

// File: rtl/deser_queue.sv
// Serial-to-parallel deserializer feeding a show-ahead word queue.
// A completed word waits in PUSH until the queue has room; while it waits the
// serial source is back-pressured through status_out.
module deser_queue
   import deser_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             data_in,
   input  logic             write_in,
   output logic             status_out,
   input  logic             flush_in,
   input  logic             dequeue_in,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] len_out,
   output logic             full_out,
   output logic             empty_out,
   output logic             overflow_out,
   output logic             underflow_out
);

   localparam int BIT_W = $clog2(WIDTH + 1);

   deser_state_t     state;
   logic [BIT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic             accept;
   logic             pop_ok;
   logic             push_ok;

   // Only a finished word stuck behind a full queue blocks the serial source.
   assign status_out = !((state == PUSH) && full_out);
   assign accept     = write_in && status_out;
   assign pop_ok     = dequeue_in && !empty_out;
   assign push_ok    = (state == PUSH) && (!full_out || pop_ok);

   // Next shift-register value for an accepted bit, in the configured bit order.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      shift_next = shift_reg;
      if (MSB_FIRST != 0) shift_next = {shift_reg[WIDTH-2:0], data_in};
      else                shift_next = {data_in, shift_reg[WIDTH-1:1]};
   end

   // Deserializer FSM: collect WIDTH bits, then hand the word to the queue.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (flush_in) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shift_reg <= shift_next;
                  bit_cnt   <= BIT_W'(1);
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (accept) begin
                  shift_reg <= shift_next;
                  if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                     bit_cnt <= '0;
                     state   <= PUSH;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            PUSH: begin
               // A bit arriving alongside the push starts the next word.
               if (push_ok) begin
                  if (accept) begin
                     shift_reg <= shift_next;
                     bit_cnt   <= BIT_W'(1);
                     state     <= SHIFT;
                  end else begin
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else if (flush_in) begin
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else begin
         if (write_in && !status_out) overflow_out  <= 1'b1;
         if (dequeue_in && empty_out) underflow_out <= 1'b1;
      end
   end

   word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush_in),
      .push    (push_ok),
      .pop     (dequeue_in),
      .wr_data (shift_reg),
      .rd_data (data_out),
      .len     (len_out),
      .full    (full_out),
      .empty   (empty_out)
   );

endmodule : deser_queue

// File: tb/tb_deser_queue.sv
// Directed bench for deser_queue: one MSB-first and one LSB-first instance
// share the same stimulus; expected values are hand-computed constants.
module tb_deser_queue;

   logic       clock = 1'b0;
   logic       reset;
   logic       data_in;
   logic       write_in;
   logic       flush_in;
   logic       dequeue_in;

   logic       m_status, m_full, m_empty, m_ovf, m_udf;
   logic [7:0] m_data;
   logic [3:0] m_len;
   logic       l_status, l_full, l_empty, l_ovf, l_udf;
   logic [7:0] l_data;
   logic [3:0] l_len;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] word;
      logic [3:0] exp_len;
      logic       exp_full;
      logic [7:0] exp_head;
   } fill_vec_t;

   typedef struct packed {
      logic [7:0] exp_msb_head;
      logic [7:0] exp_lsb_head;
      logic [3:0] exp_len_after;
   } drain_vec_t;

   fill_vec_t  fill_tbl  [8];
   drain_vec_t drain_tbl [8];

   always #5 clock = ~clock;

   deser_queue #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1)) dut_msb (
      .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
      .status_out(m_status), .flush_in(flush_in), .dequeue_in(dequeue_in),
      .data_out(m_data), .len_out(m_len), .full_out(m_full), .empty_out(m_empty),
      .overflow_out(m_ovf), .underflow_out(m_udf)
   );

   deser_queue #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(0)) dut_lsb (
      .clock(clock), .reset(reset), .data_in(data_in), .write_in(write_in),
      .status_out(l_status), .flush_in(flush_in), .dequeue_in(dequeue_in),
      .data_out(l_data), .len_out(l_len), .full_out(l_full), .empty_out(l_empty),
      .overflow_out(l_ovf), .underflow_out(l_udf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      data_in  = b;
      write_in = 1'b1;
      tick();
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   // Bits go out MSB of 'w' first; the MSB-first instance rebuilds 'w'.
   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic push_word(input logic [7:0] w);
      send_word(w);
      tick();
   endtask

   task automatic pop_word();
      dequeue_in = 1'b1;
      tick();
      dequeue_in = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " status"},   32'(m_status), 32'd1);
      check({tag, " len"},      32'(m_len),    32'd0);
      check({tag, " empty"},    32'(m_empty),  32'd1);
      check({tag, " full"},     32'(m_full),   32'd0);
      check({tag, " data"},     32'(m_data),   32'd0);
      check({tag, " overflow"}, 32'(m_ovf),    32'd0);
      check({tag, " underflow"},32'(m_udf),    32'd0);
      check({tag, " lsb len"},  32'(l_len),    32'd0);
      check({tag, " lsb data"}, 32'(l_data),   32'd0);
   endtask

   initial begin
      fill_tbl[0] = '{8'h01, 4'd1, 1'b0, 8'h01};
      fill_tbl[1] = '{8'h02, 4'd2, 1'b0, 8'h01};
      fill_tbl[2] = '{8'h03, 4'd3, 1'b0, 8'h01};
      fill_tbl[3] = '{8'h04, 4'd4, 1'b0, 8'h01};
      fill_tbl[4] = '{8'h05, 4'd5, 1'b0, 8'h01};
      fill_tbl[5] = '{8'h06, 4'd6, 1'b0, 8'h01};
      fill_tbl[6] = '{8'h07, 4'd7, 1'b0, 8'h01};
      fill_tbl[7] = '{8'h08, 4'd8, 1'b1, 8'h01};

      // After the 9th word replaces 0x01: heads 0x02..0x09, LSB-first sees them bit-reversed.
      drain_tbl[0] = '{8'h02, 8'h40, 4'd7};
      drain_tbl[1] = '{8'h03, 8'hC0, 4'd6};
      drain_tbl[2] = '{8'h04, 8'h20, 4'd5};
      drain_tbl[3] = '{8'h05, 8'hA0, 4'd4};
      drain_tbl[4] = '{8'h06, 8'h60, 4'd3};
      drain_tbl[5] = '{8'h07, 8'hE0, 4'd2};
      drain_tbl[6] = '{8'h08, 8'h10, 4'd1};
      drain_tbl[7] = '{8'h09, 8'h90, 4'd0};

      data_in    = 1'b0;
      write_in   = 1'b0;
      flush_in   = 1'b0;
      dequeue_in = 1'b0;
      reset      = 1'b0;

      repeat (2) tick();
      check_reset_state("in reset");
      @(negedge clock);
      reset = 1'b1;
      tick();
      check_reset_state("after release");

      // 1,0,1,0,0,1,0,1 -> 0xA5; count rises one cycle after the 8th bit.
      send_word(8'hA5);
      check("A5 len at last bit", 32'(m_len), 32'd0);
      tick();
      check("A5 len", 32'(m_len), 32'd1);
      check("A5 data msb", 32'(m_data), 32'hA5);
      check("A5 data lsb", 32'(l_data), 32'hA5);
      check("A5 empty", 32'(m_empty), 32'd0);
      pop_word();
      check("A5 popped empty", 32'(m_empty), 32'd1);
      check("A5 popped data", 32'(m_data), 32'd0);

      // 1,1,0,0,0,0,0,0 -> 0xC0 MSB-first, 0x03 LSB-first.
      push_word(8'hC0);
      check("C0 data msb", 32'(m_data), 32'hC0);
      check("03 data lsb", 32'(l_data), 32'h03);
      pop_word();

      // Fill to capacity.
      for (int i = 0; i < 8; i++) begin
         push_word(fill_tbl[i].word);
         check($sformatf("fill%0d len", i),  32'(m_len),  32'(fill_tbl[i].exp_len));
         check($sformatf("fill%0d full", i), 32'(m_full), 32'(fill_tbl[i].exp_full));
         check($sformatf("fill%0d head", i), 32'(m_data), 32'(fill_tbl[i].exp_head));
         check($sformatf("fill%0d lsb head", i), 32'(l_data), 32'h80);
      end
      check("full not empty", 32'(m_empty), 32'd0);

      // 9th word completes against a full queue: back-pressure, then overflow.
      send_word(8'h09);
      check("9th status", 32'(m_status), 32'd0);
      tick();
      check("9th held status", 32'(m_status), 32'd0);
      check("9th held len", 32'(m_len), 32'd8);
      send_bit(1'b1);
      check("overflow msb", 32'(m_ovf), 32'd1);
      check("overflow lsb", 32'(l_ovf), 32'd1);
      check("overflow len", 32'(m_len), 32'd8);
      pop_word();
      check("swap len", 32'(m_len), 32'd8);
      check("swap head", 32'(m_data), 32'h02);
      check("swap status", 32'(m_status), 32'd1);
      check("swap full", 32'(m_full), 32'd1);

      // Drain and confirm order, including the word pushed during the pop.
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d head", i),     32'(m_data), 32'(drain_tbl[i].exp_msb_head));
         check($sformatf("drain%0d lsb head", i), 32'(l_data), 32'(drain_tbl[i].exp_lsb_head));
         pop_word();
         check($sformatf("drain%0d len", i), 32'(m_len), 32'(drain_tbl[i].exp_len_after));
      end
      check("drained empty", 32'(m_empty), 32'd1);

      // Dequeue on empty.
      pop_word();
      check("underflow", 32'(m_udf), 32'd1);
      check("underflow len", 32'(m_len), 32'd0);
      check("underflow data", 32'(m_data), 32'd0);

      // Push and pop in the same cycle at length 3.
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      send_word(8'h44);
      dequeue_in = 1'b1;
      tick();
      dequeue_in = 1'b0;
      check("pushpop len", 32'(m_len), 32'd3);
      check("pushpop head", 32'(m_data), 32'h22);
      pop_word();
      check("pushpop head2", 32'(m_data), 32'h33);
      pop_word();
      check("pushpop head3", 32'(m_data), 32'h44);
      pop_word();
      check("pushpop empty", 32'(m_empty), 32'd1);

      // Flush mid-word with a stored word and both flags set.
      push_word(8'h55);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      check("flush len", 32'(m_len), 32'd0);
      check("flush empty", 32'(m_empty), 32'd1);
      check("flush overflow", 32'(m_ovf), 32'd0);
      check("flush underflow", 32'(m_udf), 32'd0);
      check("flush status", 32'(m_status), 32'd1);
      push_word(8'h3C);
      check("post-flush len", 32'(m_len), 32'd1);
      check("post-flush head", 32'(m_data), 32'h3C);
      pop_word();

      // Asynchronous reset mid-word with two words stored.
      push_word(8'h0A);
      push_word(8'h0B);
      check("pre-reset len", 32'(m_len), 32'd2);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("async reset");
      @(negedge clock);
      reset = 1'b1;
      push_word(8'h77);
      check("post-reset len", 32'(m_len), 32'd1);
      check("post-reset head", 32'(m_data), 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_deser_queue
